// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the digital-clock controller: mode encoding,
// per-field limits and the wrap-around increment used when presetting a field.
package clock_set_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_t;

  localparam logic [6:0] SEC_MAX  = 7'd59;
  localparam logic [6:0] MIN_MAX  = 7'd59;
  localparam logic [6:0] HOUR_MAX = 7'd23;

  // Field at its limit wraps to 0; garbage above the limit also restarts at 0.
  function automatic logic [6:0] next_field(input logic [6:0] val,
                                            input logic [6:0] max);
    if (val >= max) begin
      return 7'd0;
    end
    return val + 7'd1;
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector: one-cycle delayed copy of a level, with a selectable
// reset value so a level held high through reset does not look like an edge.
module edge_rise #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= RST_VAL;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode and timekeeping controller: second-tick prescaler with carry chain to
// the min/hour counters, plus the button-driven time-setting state machine.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [6:0] sec_val,
  input  logic [6:0] min_val,
  input  logic [6:0] hour_val,
  output logic       sec_en,
  output logic       min_en,
  output logic       hour_en,
  output logic       sec_load,
  output logic       min_load,
  output logic       hour_load,
  output logic [6:0] load_data,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(TICK_DIV / 2);

  logic          mode_rise;
  logic          inc_rise;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          wrap;
  mode_t         state;
  mode_t         state_next;

  logic          sec_en_d;
  logic          min_en_d;
  logic          hour_en_d;
  logic          sec_load_d;
  logic          min_load_d;
  logic          hour_load_d;
  logic [6:0]    load_data_d;
  logic          blink_d;

  edge_rise #(.RST_VAL(1'b1)) u_mode_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (mode_btn),
    .rise (mode_rise)
  );

  edge_rise #(.RST_VAL(1'b1)) u_inc_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (inc_btn),
    .rise (inc_rise)
  );

  // A mode press restarts the second so the first tick after RUN is a full period.
  assign wrap = (cnt == CNT_LAST);

  always_comb begin
    if (mode_rise || wrap) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MODE_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (mode_rise) begin
      unique case (state)
        MODE_RUN:      state_next = MODE_SET_HOUR;
        MODE_SET_HOUR: state_next = MODE_SET_MIN;
        MODE_SET_MIN:  state_next = MODE_SET_SEC;
        MODE_SET_SEC:  state_next = MODE_RUN;
        default:       state_next = MODE_RUN;
      endcase
    end
  end

  // A mode press in the same cycle swallows both a pending tick and an increment.
  always_comb begin
    sec_en_d    = 1'b0;
    min_en_d    = 1'b0;
    hour_en_d   = 1'b0;
    sec_load_d  = 1'b0;
    min_load_d  = 1'b0;
    hour_load_d = 1'b0;
    load_data_d = 7'd0;
    if (!mode_rise) begin
      unique case (state)
        MODE_RUN: begin
          if (wrap) begin
            sec_en_d  = 1'b1;
            min_en_d  = (sec_val == SEC_MAX);
            hour_en_d = (sec_val == SEC_MAX) && (min_val == MIN_MAX);
          end
        end
        MODE_SET_HOUR: begin
          if (inc_rise) begin
            hour_load_d = 1'b1;
            load_data_d = next_field(hour_val, HOUR_MAX);
          end
        end
        MODE_SET_MIN: begin
          if (inc_rise) begin
            min_load_d  = 1'b1;
            load_data_d = next_field(min_val, MIN_MAX);
          end
        end
        MODE_SET_SEC: begin
          if (inc_rise) begin
            sec_load_d  = 1'b1;
            load_data_d = next_field(sec_val, SEC_MAX);
          end
        end
        default: ;
      endcase
    end
    blink_d = (state_next != MODE_RUN) && (cnt_next < CNT_HALF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_en    <= 1'b0;
      min_en    <= 1'b0;
      hour_en   <= 1'b0;
      sec_load  <= 1'b0;
      min_load  <= 1'b0;
      hour_load <= 1'b0;
      load_data <= 7'd0;
      blink     <= 1'b0;
    end else begin
      sec_en    <= sec_en_d;
      min_en    <= min_en_d;
      hour_en   <= hour_en_d;
      sec_load  <= sec_load_d;
      min_load  <= min_load_d;
      hour_load <= hour_load_d;
      load_data <= load_data_d;
      blink     <= blink_d;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with TICK_DIV = 4: a directed vector
// table, hand-written reset sequences and randomized stimulus against a model.
module tb_clock_set_ctrl;

  localparam int TD = 4;

  typedef struct packed {
    logic [2:0] en;
    logic [2:0] ld;
    logic [6:0] data;
    logic [1:0] mode;
    logic       blink;
  } out_t;

  typedef struct {
    bit   mb;
    bit   ib;
    int   sv;
    int   mv;
    int   hv;
    out_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [6:0] sec_val = 7'd0;
  logic [6:0] min_val = 7'd0;
  logic [6:0] hour_val = 7'd0;
  logic       sec_en, min_en, hour_en;
  logic       sec_load, min_load, hour_load;
  logic [6:0] load_data;
  logic [1:0] mode;
  logic       blink;

  int checks = 0;
  int errors = 0;

  int m_mode;
  int m_cnt;
  bit m_pm;
  bit m_pi;
  out_t m_exp;

  vec_t tbl[$];

  clock_set_ctrl #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode_btn  (mode_btn),
    .inc_btn   (inc_btn),
    .sec_val   (sec_val),
    .min_val   (min_val),
    .hour_val  (hour_val),
    .sec_en    (sec_en),
    .min_en    (min_en),
    .hour_en   (hour_en),
    .sec_load  (sec_load),
    .min_load  (min_load),
    .hour_load (hour_load),
    .load_data (load_data),
    .mode      (mode),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit mb, bit ib, int sv, int mv, int hv,
                              logic [2:0] en, logic [2:0] ld, int data,
                              int md, bit bl);
    vec_t v;
    v.mb = mb; v.ib = ib; v.sv = sv; v.mv = mv; v.hv = hv;
    v.exp.en = en; v.exp.ld = ld; v.exp.data = 7'(data);
    v.exp.mode = 2'(md); v.exp.blink = bl;
    return v;
  endfunction

  function automatic int inc_wrap(int v, int max);
    if (v > max) return 0;
    return (v + 1) % (max + 1);
  endfunction

  task automatic applyStimulus(bit mb, bit ib, int sv, int mv, int hv);
    mode_btn = mb;
    inc_btn  = ib;
    sec_val  = 7'(sv);
    min_val  = 7'(mv);
    hour_val = 7'(hv);
  endtask

  task automatic checkOutput(string name, out_t exp);
    out_t act;
    act.en    = {hour_en, min_en, sec_en};
    act.ld    = {hour_load, min_load, sec_load};
    act.data  = load_data;
    act.mode  = mode;
    act.blink = blink;
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got en=%b ld=%b data=%0d mode=%0d blink=%b, expected en=%b ld=%b data=%0d mode=%0d blink=%b",
               name, act.en, act.ld, act.data, act.mode, act.blink,
               exp.en, exp.ld, exp.data, exp.mode, exp.blink);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_cnt  = 0;
    m_pm   = 1'b1;
    m_pi   = 1'b1;
    m_exp  = '0;
  endtask

  // One clock of behaviour, computed from the current input levels.
  task automatic model_step();
    bit mr, ir, was_last;
    int sv, mv, hv;
    mr = mode_btn && !m_pm;
    ir = inc_btn && !m_pi;
    m_pm = mode_btn;
    m_pi = inc_btn;
    sv = int'(sec_val); mv = int'(min_val); hv = int'(hour_val);
    m_exp = '0;
    was_last = (m_cnt == TD - 1);
    if (mr) begin
      m_mode = (m_mode + 1) % 4;
      m_cnt  = 0;
    end else begin
      if (m_mode == 0 && was_last) begin
        m_exp.en[0] = 1'b1;
        m_exp.en[1] = (sv == 59);
        m_exp.en[2] = (sv == 59 && mv == 59);
      end
      if (m_mode != 0 && ir) begin
        case (m_mode)
          1: begin m_exp.ld = 3'b100; m_exp.data = 7'(inc_wrap(hv, 23)); end
          2: begin m_exp.ld = 3'b010; m_exp.data = 7'(inc_wrap(mv, 59)); end
          default: begin m_exp.ld = 3'b001; m_exp.data = 7'(inc_wrap(sv, 59)); end
        endcase
      end
      m_cnt = (m_cnt + 1) % TD;
    end
    m_exp.mode  = 2'(m_mode);
    m_exp.blink = (m_mode != 0) && (m_cnt < TD / 2);
  endtask

  task automatic do_reset(bit mb);
    rst = 1'b1;
    applyStimulus(mb, 1'b0, 5, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", out_t'(0));
    rst = 1'b0;
    model_reset();
  endtask

  task automatic model_cycle(string name, bit mb, bit ib, int sv, int mv, int hv);
    applyStimulus(mb, ib, sv, mv, hv);
    @(posedge clk);
    model_step();
    #1;
    checkOutput(name, m_exp);
  endtask

  function automatic int pick_val();
    case ($urandom_range(0, 5))
      0: return 59;
      1: return 23;
      2: return 58;
      3: return 24 + $urandom_range(0, 103);
      default: return $urandom_range(0, 60);
    endcase
  endfunction

  initial begin
    // Directed table: one entry per clock edge after reset release.
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b000,3'b000, 0,0,0));
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b000,3'b000, 0,0,0));
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b000,3'b000, 0,0,0));
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b001,3'b000, 0,0,0));
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b000,3'b000, 0,0,0));
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b000,3'b000, 0,0,0));
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b000,3'b000, 0,0,0));
    tbl.push_back(mk(0,0,59,10, 0, 3'b011,3'b000, 0,0,0));
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b000,3'b000, 0,0,0));
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b000,3'b000, 0,0,0));
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b000,3'b000, 0,0,0));
    tbl.push_back(mk(0,0,59,59, 0, 3'b111,3'b000, 0,0,0));
    tbl.push_back(mk(1,0, 5, 0, 0, 3'b000,3'b000, 0,1,1));
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b000,3'b000, 0,1,1));
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b000,3'b000, 0,1,0));
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b000,3'b000, 0,1,0));
    tbl.push_back(mk(0,0,59,59, 0, 3'b000,3'b000, 0,1,1));
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b000,3'b000, 0,1,1));
    tbl.push_back(mk(0,1, 5, 0,23, 3'b000,3'b100, 0,1,0));
    tbl.push_back(mk(0,0, 5, 0,30, 3'b000,3'b000, 0,1,0));
    tbl.push_back(mk(0,1, 5, 0,30, 3'b000,3'b100, 0,1,1));
    tbl.push_back(mk(0,0, 5, 0, 7, 3'b000,3'b000, 0,1,1));
    tbl.push_back(mk(0,1, 5, 0, 7, 3'b000,3'b100, 8,1,0));
    tbl.push_back(mk(1,0, 5, 0, 7, 3'b000,3'b000, 0,2,1));
    tbl.push_back(mk(0,1, 5,41, 7, 3'b000,3'b010,42,2,1));
    tbl.push_back(mk(0,0, 5,41, 7, 3'b000,3'b000, 0,2,0));
    tbl.push_back(mk(1,1, 5,41, 7, 3'b000,3'b000, 0,3,1));
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b000,3'b000, 0,3,1));
    tbl.push_back(mk(0,1,59, 0, 0, 3'b000,3'b001, 0,3,0));
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b000,3'b000, 0,3,0));
    tbl.push_back(mk(1,0, 5, 0, 0, 3'b000,3'b000, 0,0,0));
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b000,3'b000, 0,0,0));
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b000,3'b000, 0,0,0));
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b000,3'b000, 0,0,0));
    tbl.push_back(mk(0,0, 5, 0, 0, 3'b001,3'b000, 0,0,0));

    do_reset(1'b0);
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].mb, tbl[i].ib, tbl[i].sv, tbl[i].mv, tbl[i].hv);
      @(posedge clk);
      #1;
      checkOutput($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // Mode button held through reset release must not count as a press.
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) model_cycle("held_mode_btn", 1, 0, 5, 0, 0);
    model_cycle("held_mode_release", 0, 0, 5, 0, 0);
    if (m_mode != 0) begin
      errors++;
      $display("[TB] FAIL held_mode_model: model mode %0d, required 0", m_mode);
    end
    checks++;

    // Reset asserted while a load strobe is high clears it asynchronously.
    do_reset(1'b0);
    model_cycle("enter_set_hour", 1, 0, 5, 0, 12);
    model_cycle("release_mode", 0, 0, 5, 0, 12);
    model_cycle("hour_load_13", 0, 1, 5, 0, 12);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_mid_load", out_t'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    applyStimulus(0, 0, 5, 0, 0);

    // Randomized stimulus against the reference model.
    begin
      bit mb = 1'b0;
      bit ib = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 9) == 0) mb = ~mb;
        ib = ($urandom_range(0, 2) == 0) ? ~ib : ib;
        model_cycle($sformatf("random[%0d]", i), mb, ib, pick_val(), pick_val(), pick_val());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
